pmc_dump_unit: RTL and testbench

PMC_DUMP_UNIT -- requirements
Module: pmc_dump_unit

---
 rtl/pmc_pkg.sv | 21 ++
 rtl/pmc_snapshot_bank.sv | 29 ++
 rtl/pmc_dump_unit.sv | 144 ++++++++++++++
 tb/tb_pmc_dump_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pmc_pkg.sv
// Shared definitions for the PMC counter dump path: defaults, header magic,
// frame FSM encoding and an index-width helper.
package pmc_pkg;

  localparam int unsigned PMC_NUM_CNT   = 24;
  localparam int unsigned PMC_CW        = 32;
  localparam logic [31:0] PMC_HDR_MAGIC = 32'h504D_4300;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } pmc_state_e;

  // Index width for n entries; at least one bit so a single-counter build still has a port.
  function automatic int unsigned pmc_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmc_snapshot_bank.sv
// Snapshot register bank: parallel load of every counter, single indexed read.
// Deliberately has no reset; contents are only meaningful after a load.
module pmc_snapshot_bank
  import pmc_pkg::*;
#(
  parameter int unsigned NUM_CNT = PMC_NUM_CNT,
  parameter int unsigned CW      = PMC_CW,
  parameter int unsigned IDXW    = pmc_idx_w(NUM_CNT)
) (
  input  logic                         clk,
  input  logic                         load,
  input  logic [NUM_CNT-1:0][CW-1:0]   din,
  input  logic [IDXW-1:0]              rd_idx,
  output logic [CW-1:0]                rd_data
);

  logic [NUM_CNT-1:0][CW-1:0] mem;

  always_ff @(posedge clk) begin
    if (load) begin
      mem <= din;
    end
  end

  always_comb begin
    rd_data = mem[rd_idx];
  end

endmodule

// File: rtl/pmc_dump_unit.sv
// Captures a frozen snapshot of all PMC counters on request and streams it as
// a valid/ready frame: header, counters, running-XOR checksum.
module pmc_dump_unit
  import pmc_pkg::*;
#(
  parameter int unsigned NUM_CNT = PMC_NUM_CNT,
  parameter int unsigned CW      = PMC_CW
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CNT-1:0][CW-1:0]   cnt_in,
  input  logic                         snap_req,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [CW-1:0]                out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned     IDXW     = pmc_idx_w(NUM_CNT);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CNT - 1);
  localparam logic [CW-1:0]   HDR_WORD = CW'(PMC_HDR_MAGIC | 32'(NUM_CNT));

  pmc_state_e      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [CW-1:0]   data_q, data_d;
  logic [CW-1:0]   csum_q, csum_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            ovr_q, ovr_d;

  logic            load;
  logic            xfer;
  logic [IDXW-1:0] rd_idx;
  logic [CW-1:0]   rd_data;

  pmc_snapshot_bank #(
    .NUM_CNT (NUM_CNT),
    .CW      (CW),
    .IDXW    (IDXW)
  ) u_bank (
    .clk     (clk),
    .load    (load),
    .din     (cnt_in),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      csum_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      csum_q  <= csum_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
    end
  end

  // Output word is registered; the next word is fetched from the bank in the
  // transfer cycle so back-to-back transfers need no extra pipeline stage.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    csum_d  = csum_q;
    valid_d = valid_q;
    last_d  = last_q;
    ovr_d   = ovr_q;
    load    = 1'b0;
    rd_idx  = '0;
    xfer    = valid_q & out_ready;

    if (snap_req && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (snap_req) begin
          load    = 1'b1;
          ovr_d   = 1'b0;
          state_d = HDR;
          valid_d = 1'b1;
          data_d  = HDR_WORD;
          last_d  = 1'b0;
          csum_d  = HDR_WORD;
          idx_d   = '0;
        end
      end
      HDR: begin
        if (xfer) begin
          state_d = DATA;
          idx_d   = '0;
          data_d  = rd_data;
        end
      end
      DATA: begin
        if (idx_q != LAST_IDX) begin
          rd_idx = idx_q + 1'b1;
        end
        if (xfer) begin
          csum_d = csum_q ^ data_q;
          if (idx_q == LAST_IDX) begin
            state_d = CSUM;
            data_d  = csum_q ^ data_q;
            last_d  = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = rd_data;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          data_d  = '0;
          csum_d  = '0;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_pmc_dump_unit.sv
// Directed bench for pmc_dump_unit: expected frames are queued at capture and
// popped as words transfer.
module tb_pmc_dump_unit;
  import pmc_pkg::*;

  localparam int unsigned N = 24;
  localparam int unsigned W = 32;
  localparam logic [W-1:0] HDR_W = 32'h504D_4318;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N-1:0][W-1:0]    cnt_in;
  logic                   snap_req;
  logic                   out_ready;
  logic                   out_valid;
  logic [W-1:0]           out_data;
  logic                   out_last;
  logic                   busy;
  logic                   overrun;

  int checks   = 0;
  int failures = 0;
  logic [W:0] exp_q[$];   // {last, data}

  always #5 clk = ~clk;

  pmc_dump_unit #(
    .NUM_CNT (N),
    .CW      (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cnt_in    (cnt_in),
    .snap_req  (snap_req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [N-1:0][W-1:0] v);
    logic [W-1:0] cs;
    cs = HDR_W;
    exp_q.push_back({1'b0, HDR_W});
    for (int i = 0; i < int'(N); i++) begin
      exp_q.push_back({1'b0, v[i]});
      cs = cs ^ v[i];
    end
    exp_q.push_back({1'b1, cs});
  endtask

  // Called at a negedge; pulses snap_req across one rising edge and expects
  // the header to be valid one cycle later.
  task automatic capture();
    snap_req = 1'b1;
    push_frame(cnt_in);
    @(negedge clk);
    snap_req = 1'b0;
    check("latency_valid", 64'(out_valid), 64'd1);
    check("latency_busy", 64'(busy), 64'd1);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1-0-0-1.
  // snap_at: pulse snap_req while that many words have already transferred.
  // stop_at: return early once that many words have transferred.
  task automatic drain(input int mode, input int snap_at, input int stop_at, output int xfers);
    int   cyc;
    logic stall;
    logic fired;
    logic [W-1:0] held;
    logic [W:0]   e;
    logic [3:0]   pat;
    cyc   = 0;
    stall = 1'b0;
    fired = 1'b0;
    held  = '0;
    pat   = 4'b1001;
    xfers = 0;
    while (exp_q.size() > 0 && cyc < 400 && xfers != stop_at) begin
      out_ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
      if (xfers == snap_at && !fired) begin
        snap_req = 1'b1;
        fired    = 1'b1;
      end else begin
        snap_req = 1'b0;
      end
      if (stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(held));
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check($sformatf("word%0d_data", xfers), 64'(out_data), 64'(e[W-1:0]));
        check($sformatf("word%0d_last", xfers), 64'(out_last), 64'(e[W]));
        xfers++;
        stall = 1'b0;
      end else begin
        stall = out_valid;
        held  = out_data;
      end
      cyc++;
      @(negedge clk);
    end
    snap_req  = 1'b0;
    out_ready = 1'b0;
    if (stop_at < 0) begin
      check("frame_complete", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    snap_req  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < int'(N); i++) cnt_in[i] = W'(i + 1);

    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic dump, cnt_in[i] = i+1, ready held high
    check("basic_hdr_word", 64'(out_data), 64'd0);
    capture();
    check("basic_first_word", 64'(out_data), 64'(HDR_W));
    drain(0, -1, -1, n);
    check("basic_xfers", 64'(n), 64'd26);
    check("basic_end_valid", 64'(out_valid), 64'd0);
    check("basic_end_busy", 64'(busy), 64'd0);
    check("basic_overrun", 64'(overrun), 64'd0);

    // Backpressure with varied data
    for (int i = 0; i < int'(N); i++) cnt_in[i] = W'((i * 32'h0101_0101) ^ 32'hA5C3_0F96);
    capture();
    drain(1, -1, -1, n);
    check("bp_xfers", 64'(n), 64'd26);
    check("bp_end_valid", 64'(out_valid), 64'd0);

    // Snapshot freeze: inputs change right after capture
    for (int i = 0; i < int'(N); i++) cnt_in[i] = W'(i * 7 + 100);
    capture();
    for (int i = 0; i < int'(N); i++) cnt_in[i] = '1;
    drain(0, -1, -1, n);
    check("freeze_xfers", 64'(n), 64'd26);

    // Overrun: request during DATA index 5
    for (int i = 0; i < int'(N); i++) cnt_in[i] = W'($urandom);
    capture();
    drain(0, 6, -1, n);
    check("ovr_xfers", 64'(n), 64'd26);
    check("ovr_flag", 64'(overrun), 64'd1);
    check("ovr_no_new_frame", 64'(out_valid), 64'd0);
    repeat (3) @(negedge clk);
    check("ovr_sticky", 64'(overrun), 64'd1);
    capture();
    check("ovr_cleared", 64'(overrun), 64'd0);
    drain(0, -1, -1, n);
    check("ovr_next_xfers", 64'(n), 64'd26);

    // Reset during DATA index 10
    for (int i = 0; i < int'(N); i++) cnt_in[i] = W'(32'h1000_0000 + i);
    capture();
    drain(0, -1, 11, n);
    check("mid_pre_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_last", 64'(out_last), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_no_resume", 64'(out_valid), 64'd0);
    for (int i = 0; i < int'(N); i++) cnt_in[i] = W'(32'hBEEF_0000 | (i * 3));
    capture();
    check("mid_new_hdr", 64'(out_data), 64'(HDR_W));
    drain(0, -1, -1, n);
    check("mid_new_xfers", 64'(n), 64'd26);

    // snap_req coincident with the final checksum transfer
    capture();
    push_frame(cnt_in);
    exp_q.delete();
    push_frame(cnt_in);
    drain(0, int'(N) + 1, -1, n);
    check("sim_xfers", 64'(n), 64'd26);
    check("sim_valid", 64'(out_valid), 64'd0);
    check("sim_busy", 64'(busy), 64'd0);
    check("sim_overrun", 64'(overrun), 64'd1);
    repeat (3) @(negedge clk);
    check("sim_still_idle", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
